// File: rtl/three_stage_pipeline_if.sv
// -----------------------------------------------------------------------------
// three_stage_pipeline_if
//   Bundle of the operand/result signals of the three-operand mean pipeline.
//   The block itself keeps its historical flat port list, so that positional
//   instantiations (avg, clk, a, b, c, ...) stay valid. This bundle is used by
//   surrounding logic and benches to carry the same signals as one object.
//
//   Signals:
//     a, b, c    operand triple (unsigned, WIDTH bits each)
//     avg        truncated mean of the triple (WIDTH bits)
//     out_valid  result qualifier
//
//   Modports:
//     master  drives the operands, observes the result (the producer side)
//     slave   observes the operands, drives the result (the pipeline side)
// -----------------------------------------------------------------------------
interface three_stage_pipeline_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] avg;
  logic             out_valid;

  modport master (
    output a,
    output b,
    output c,
    input  avg,
    input  out_valid
  );

  modport slave (
    input  a,
    input  b,
    input  c,
    output avg,
    output out_valid
  );
endinterface : three_stage_pipeline_if

// File: rtl/three_stage_pipeline.sv
// -----------------------------------------------------------------------------
// three_stage_pipeline
//   Fully pipelined truncated mean of three unsigned operands:
//     avg = floor((a + b + c) / 3)
//   One triple accepted per clock, no stalls. A triple sampled on rising edge k
//   is visible on avg right after edge k+2.
//
//   Ports (positional order is part of the contract):
//     avg        out  WIDTH  registered mean of the triple sampled two edges ago
//     clk        in   1      rising-edge clock
//     a, b, c    in   WIDTH  unsigned operands
//     rst_n      in   1      asynchronous active-low reset
//     out_valid  out  1      high once avg derives from post-reset inputs
//
//   Every register, datapath included, is cleared by rst_n so that avg reads
//   zero during reset and no stale or unknown operand survives a reset.
// -----------------------------------------------------------------------------
module three_stage_pipeline #(
  parameter int WIDTH = 8
) (
  output logic [WIDTH-1:0] avg,
  input  logic             clk,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic             rst_n,
  output logic             out_valid
);

  // Two extra bits hold 3*(2^WIDTH-1) without overflow.
  localparam int SUM_W = WIDTH + 2;

  // Exact truncating division by the constant 3. The quotient of a value no
  // larger than 3*(2^WIDTH-1) always fits back into WIDTH bits.
  function automatic logic [WIDTH-1:0] div3(input logic [SUM_W-1:0] s);
    return WIDTH'(s / SUM_W'(3));
  endfunction

  // Widen before adding so the carry bits are kept.
  function automatic logic [SUM_W-1:0] sum3(input logic [WIDTH-1:0] x,
                                            input logic [WIDTH-1:0] y,
                                            input logic [WIDTH-1:0] z);
    return SUM_W'(x) + SUM_W'(y) + SUM_W'(z);
  endfunction

  logic [WIDTH-1:0] a_p0_d, a_p0_q;
  logic [WIDTH-1:0] b_p0_d, b_p0_q;
  logic [WIDTH-1:0] c_p0_d, c_p0_q;
  logic [SUM_W-1:0] sum_p1_d, sum_p1_q;
  logic [WIDTH-1:0] avg_p2_d, avg_p2_q;
  logic             vld_p0_d, vld_p0_q;
  logic             vld_p1_d, vld_p1_q;
  logic             vld_p2_d, vld_p2_q;

  always_comb begin
    // ---- stage 0: operand capture ----
    a_p0_d   = a;
    b_p0_d   = b;
    c_p0_d   = c;
    // A constant 1 enters the valid chain every cycle after reset, so it
    // reaches the output exactly when the first real result does.
    vld_p0_d = 1'b1;
    // ---- stage 1: sum ----
    sum_p1_d = sum3(a_p0_q, b_p0_q, c_p0_q);
    vld_p1_d = vld_p0_q;
    // ---- stage 2: divide ----
    avg_p2_d = div3(sum_p1_q);
    vld_p2_d = vld_p1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_p0_q   <= '0;
      b_p0_q   <= '0;
      c_p0_q   <= '0;
      sum_p1_q <= '0;
      avg_p2_q <= '0;
      vld_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      a_p0_q   <= a_p0_d;
      b_p0_q   <= b_p0_d;
      c_p0_q   <= c_p0_d;
      sum_p1_q <= sum_p1_d;
      avg_p2_q <= avg_p2_d;
      vld_p0_q <= vld_p0_d;
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
    end
  end

  assign avg       = avg_p2_q;
  assign out_valid = vld_p2_q;

endmodule : three_stage_pipeline

// File: tb/tb_three_stage_pipeline.sv
module tb_three_stage_pipeline;

  localparam int WIDTH = 8;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic clk;
  logic rst_n;

  three_stage_pipeline_if #(.WIDTH(WIDTH)) bus ();

  three_stage_pipeline #(.WIDTH(WIDTH)) dut (
    .avg       (bus.avg),
    .clk       (clk),
    .a         (bus.a),
    .b         (bus.b),
    .c         (bus.c),
    .rst_n     (rst_n),
    .out_valid (bus.out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: list of operand sums sampled on each rising edge since
  // the last reset release. After the n-th edge the output shows the mean of
  // the triple from edge n-2 (1-based), valid only from n = 3 onward.
  int hist[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Apply one triple, let one rising edge sample it, then compare 1 ns later.
  task automatic step(input int av, input int bv, input int cv, input string tag);
    int n;
    int exp_avg;
    logic exp_vld;
    bus.a = WIDTH'(av);
    bus.b = WIDTH'(bv);
    bus.c = WIDTH'(cv);
    @(posedge clk);
    hist.push_back(av + bv + cv);
    n = hist.size();
    exp_vld = (n >= 3);
    exp_avg = exp_vld ? hist[n-3] / 3 : 0;
    #1;
    chk($sformatf("%s_avg_n%0d", tag, n), 32'(bus.avg), 32'(exp_avg));
    chk($sformatf("%s_vld_n%0d", tag, n), 32'(bus.out_valid), 32'(exp_vld));
  endtask

  task automatic hold3(input int av, input int bv, input int cv, input string tag);
    for (int i = 0; i < 3; i++) step(av, bv, cv, tag);
  endtask

  // Assert reset between edges, check the asynchronous clear, hold it across
  // an edge, then release on a falling edge.
  task automatic pulse_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    chk({tag, "_async_avg"}, 32'(bus.avg), 32'd0);
    chk({tag, "_async_vld"}, 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_held_avg"}, 32'(bus.avg), 32'd0);
    chk({tag, "_held_vld"}, 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    hist.delete();
  endtask

  initial begin
    int r;
    rst_n = 1'b0;
    bus.a = 8'd3;
    bus.b = 8'd6;
    bus.c = 8'd9;

    // Reset held with live inputs on the pins.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_hold_avg", 32'(bus.avg), 32'd0);
      chk("rst_hold_vld", 32'(bus.out_valid), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Basic fill and the 3-phase sequence.
    hold3(3, 6, 9, "fill");
    hold3(4, 8, 12, "ph2");
    hold3(9, 9, 9, "ph3");

    // Truncation and boundaries.
    hold3(1, 1, 0, "t110");
    hold3(1, 1, 1, "t111");
    hold3(2, 2, 1, "t221");
    hold3(MAXV, MAXV, MAXV, "tmax");
    hold3(MAXV, MAXV, MAXV - 1, "tmaxm1");
    hold3(0, 0, 0, "tzero");

    // Back-to-back, one triple per cycle, then drain.
    step(0, 0, 0, "b2b");
    step(MAXV, MAXV, MAXV, "b2b");
    step(10, 20, 31, "b2b");
    step(100, 0, 0, "b2b");
    step(100, 0, 0, "b2b");
    step(100, 0, 0, "b2b");

    // Reset while results are in flight, then refill.
    step(50, 60, 70, "pre_rst");
    step(200, 201, 202, "pre_rst");
    pulse_reset("mid_rst");
    step(7, 8, 9, "refill");
    step(1, 2, 3, "refill");
    step(30, 30, 30, "refill");
    step(30, 30, 30, "refill");

    // Every reachable sum, exercising the divider over its whole range.
    for (int s = 0; s <= 3 * MAXV; s++) begin
      int av, bv, cv;
      av = (s > MAXV) ? MAXV : s;
      bv = (s - av > MAXV) ? MAXV : s - av;
      cv = s - av - bv;
      step(av, bv, cv, "sweep");
    end
    step(0, 0, 0, "sweep");
    step(0, 0, 0, "sweep");

    // Random operands, occasionally pinned to the extremes.
    for (int i = 0; i < 300; i++) begin
      int av, bv, cv;
      r  = int'($urandom_range(0, 7));
      av = (r == 0) ? MAXV : int'($urandom_range(0, MAXV));
      bv = (r == 1) ? 0    : int'($urandom_range(0, MAXV));
      cv = (r == 2) ? MAXV : int'($urandom_range(0, MAXV));
      step(av, bv, cv, "rand");
      if (i == 150) pulse_reset("rand_rst");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Backstop so the run always ends even if a wait misbehaves.
  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=%0d", checks, 0);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "time limit reached");
  end

endmodule : tb_three_stage_pipeline
